// File: rtl/control_sequencer.sv
// Moore control FSM stepping fetch (T0..T2) and execute (T3..T7) for the RISC datapath,
// with a bounded memory-ready wait, a sticky handshake fault, stop and halt.
module control_sequencer #(
    parameter int WAIT_LIMIT = 255,
    parameter int ALU_OP_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    input  logic                stop,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                Write,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Cout,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                mem_fault
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_HALT, C_LD, C_LDI, C_ST, C_ALU, C_ALUI
    } cls_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_mem_fault;
    logic                  w_fault_set;
    logic [4:0]            w_opcode;
    cls_t                  w_cls;
    logic [ALU_OP_W-1:0]   w_alu;
    logic                  w_is_wait;
    logic                  w_instr_end;
    logic                  w_unused_ir;

    assign w_opcode    = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    // Opcode class and ALU function; anything not listed executes as nop.
    always_comb begin
        w_cls = C_NOP;
        w_alu = ALU_ADD;
        case (w_opcode)
            5'b00000: w_cls = C_LD;
            5'b00001: w_cls = C_LDI;
            5'b00010: w_cls = C_ST;
            5'b00011: w_cls = C_ALU;
            5'b00100: begin w_cls = C_ALU;  w_alu = ALU_SUB; end
            5'b00101: begin w_cls = C_ALU;  w_alu = ALU_AND; end
            5'b00110: begin w_cls = C_ALU;  w_alu = ALU_OR;  end
            5'b01100: w_cls = C_ALUI;
            5'b01101: begin w_cls = C_ALUI; w_alu = ALU_AND; end
            5'b01110: begin w_cls = C_ALUI; w_alu = ALU_OR;  end
            5'b11011: w_cls = C_HALT;
            default:  ;
        endcase
    end

    assign w_is_wait = (r_state == S_T1) ||
                       (r_state == S_T6 && w_cls == C_LD) ||
                       (r_state == S_T7 && w_cls == C_ST);

    assign w_instr_end = (r_state == S_T2 && w_cls == C_NOP) ||
                         (r_state == S_T5 && (w_cls == C_ALU || w_cls == C_ALUI || w_cls == C_LDI)) ||
                         (r_state == S_T7 && (w_cls == C_LD || w_cls == C_ST));

    always_comb begin
        w_next      = r_state;
        w_fault_set = 1'b0;
        case (r_state)
            S_RST:   w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = S_T2;
            S_T2:    w_next = (w_cls == C_HALT) ? S_HALT : S_T3;
            S_T3:    w_next = S_T4;
            S_T4:    w_next = S_T5;
            S_T5:    w_next = S_T6;
            S_T6:    w_next = S_T7;
            S_T7:    w_next = S_T0;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RST;
        endcase
        if (w_instr_end)
            w_next = stop ? S_HALT : S_T0;
        // A wait state only advances on mem_ready; the counter bounds how long it may stall.
        if (w_is_wait && !mem_ready) begin
            if (r_wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                w_next      = S_HALT;
                w_fault_set = 1'b1;
            end else begin
                w_next = r_state;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RST;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_is_wait)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            if (w_fault_set)
                r_mem_fault <= 1'b1;
        end
    end

    assign mem_fault = r_mem_fault;

    // Moore decode: strictly a function of state and opcode class.
    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; Gra = 1'b0; Grb = 1'b0;
        Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        alu_op = ALU_ADD;
        run    = (r_state != S_HALT);
        case (r_state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (w_cls == C_ALU || w_cls == C_ALUI) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_cls == C_LDI || w_cls == C_LD || w_cls == C_ST) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end
            end
            S_T4: begin
                if (w_cls == C_ALU) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_alu;
                end else if (w_cls != C_NOP && w_cls != C_HALT) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = w_alu;
                end
            end
            S_T5: begin
                if (w_cls == C_ALU || w_cls == C_ALUI || w_cls == C_LDI) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_cls == C_LD || w_cls == C_ST) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end
            end
            S_T6: begin
                if (w_cls == C_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (w_cls == C_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (w_cls == C_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_cls == C_ST) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: instruction step tables built from the opcode
// rules, random wait delays/stop/noise, plus directed reset, stop, halt and timeout cases.
module tb_control_sequencer;

    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        mem_ready, stop;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic [3:0]  alu_op;
    logic        run, mem_fault;

    always #5 clk = ~clk;

    control_sequencer #(.WAIT_LIMIT(WL), .ALU_OP_W(4)) dut (
        .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .run(run), .mem_fault(mem_fault)
    );

    typedef struct packed {
        logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Cout;
        logic Gra, Grb, Grc, Rin, Rout, BAout;
        logic [3:0] alu_op;
        logic run, mem_fault;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  wt;
    } step_t;

    outs_t obs;
    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout,
                  Cout, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, mem_fault};

    int n_chk = 0, n_pass = 0, n_fail = 0;
    step_t steps[$];

    task automatic check(input string tag, input outs_t exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic outs_t idle(input logic r, input logic f);
        outs_t o = '0;
        o.run = r;
        o.mem_fault = f;
        return o;
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00100:           return 4'd1;
            5'b00101, 5'b01101: return 4'd2;
            5'b00110, 5'b01110: return 4'd3;
            default:            return 4'd0;
        endcase
    endfunction

    // Expected step list of one instruction, straight from the opcode tables.
    task automatic build(input logic [4:0] op);
        outs_t o;
        bit reg_alu, imm_alu, is_ldi, is_ld, is_st;
        reg_alu = (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110});
        imm_alu = (op inside {5'b01100, 5'b01101, 5'b01110});
        is_ldi  = (op == 5'b00001);
        is_ld   = (op == 5'b00000);
        is_st   = (op == 5'b00010);
        steps.delete();
        o = idle(1, 0); o.PCout = 1; o.MARin = 1; o.IncPC = 1; o.Zin = 1;   steps.push_back('{o, 1'b0});
        o = idle(1, 0); o.Zlowout = 1; o.PCin = 1; o.Read = 1; o.MDRin = 1; steps.push_back('{o, 1'b1});
        o = idle(1, 0); o.MDRout = 1; o.IRin = 1;                           steps.push_back('{o, 1'b0});
        if (reg_alu || imm_alu || is_ldi || is_ld || is_st) begin
            o = idle(1, 0); o.Grb = 1; o.Yin = 1;
            if (reg_alu || imm_alu) o.Rout = 1; else o.BAout = 1;
            steps.push_back('{o, 1'b0});
            o = idle(1, 0); o.Zin = 1; o.alu_op = alu_of(op);
            if (reg_alu) begin o.Grc = 1; o.Rout = 1; end else o.Cout = 1;
            steps.push_back('{o, 1'b0});
            o = idle(1, 0); o.Zlowout = 1;
            if (is_ld || is_st) o.MARin = 1; else begin o.Gra = 1; o.Rin = 1; end
            steps.push_back('{o, 1'b0});
        end
        if (is_ld) begin
            o = idle(1, 0); o.Read = 1; o.MDRin = 1;                steps.push_back('{o, 1'b1});
            o = idle(1, 0); o.MDRout = 1; o.Gra = 1; o.Rin = 1;     steps.push_back('{o, 1'b0});
        end
        if (is_st) begin
            o = idle(1, 0); o.Gra = 1; o.Rout = 1; o.MDRin = 1;     steps.push_back('{o, 1'b0});
            o = idle(1, 0); o.Write = 1;                            steps.push_back('{o, 1'b1});
        end
    endtask

    // Asserts reset between edges, checks RST outputs, releases it on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("reset_async", idle(1, 0));
        @(negedge clk);
        check("reset_rst", idle(1, 0));
        reset = 1'b0;
    endtask

    // Runs one instruction from T0. d1/d2: mem_ready-low cycles in the 1st/2nd wait state.
    // abort_cyc >= 0 asserts reset mid-cycle at that cycle. halted=1 means a reset is needed.
    task automatic run_instr(input logic [31:0] instr, input int d1, input int d2,
                             input bit stop_end, input int abort_cyc, output bit halted);
        int    cyc = 0, wi = 0, dly, n, last;
        bit    fault = 0;
        step_t s;
        halted = 0;
        build(instr[31:27]);
        last = steps.size() - 1;
        for (int i = 0; i <= last; i++) begin
            s = steps[i];
            dly = 0;
            if (s.wt) begin dly = (wi == 0) ? d1 : d2; wi++; end
            n = !s.wt ? 1 : (dly >= WL) ? WL : dly + 1;
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                check($sformatf("op%02h step%0d cyc%0d", instr[31:27], i, c), s.o);
                if (cyc == 0) ir = instr;
                if (cyc == abort_cyc) begin
                    #2 reset = 1'b1;
                    #1 check("abort_async", idle(1, 0));
                    halted = 1;
                    return;
                end
                mem_ready = s.wt ? (c == dly) : 1'($urandom);
                stop = (i == last && c == n - 1) ? stop_end : 1'($urandom);
                cyc++;
            end
            if (s.wt && dly >= WL) begin fault = 1; break; end
        end
        if (fault || stop_end || instr[31:27] == 5'b11011) begin
            halted = 1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check($sformatf("halt op%02h k%0d", instr[31:27], k), idle(0, fault));
                mem_ready = 1'($urandom);
                stop = 1'($urandom);
            end
        end
    endtask

    logic [4:0] ops[12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                            5'b00110, 5'b01100, 5'b01101, 5'b01110, 5'b11010, 5'b11011};

    initial begin
        bit          h;
        logic [4:0]  op;
        int          d1, d2;
        reset = 1'b1; ir = '0; mem_ready = 1'b0; stop = 1'b0;
        #1 check("reset_initial", idle(1, 0));
        @(negedge clk);
        reset = 1'b0;

        // add, zero wait, then a ld and st with stretched handshakes
        run_instr(32'h18A20000, 0, 0, 0, -1, h);
        run_instr(32'h00A20000, 3, 3, 0, -1, h);
        run_instr(32'h10A20000, 0, 2, 0, -1, h);
        run_instr(32'h60A20005, 1, 0, 0, -1, h);
        // stop at instruction end of add, then the halt opcode
        run_instr(32'h18A20000, 0, 0, 1, -1, h);
        do_reset();
        run_instr(32'hD8000000, 0, 0, 0, -1, h);
        do_reset();
        // nop with stop at T2, illegal opcode as nop
        run_instr(32'hD0000000, 0, 0, 1, -1, h);
        do_reset();
        run_instr(32'hF8000000, 2, 0, 0, -1, h);
        // handshake timeout in T1 and in ld T6
        run_instr(32'h18A20000, WL, 0, 0, -1, h);
        do_reset();
        run_instr(32'h00A20000, 0, WL + 1, 0, -1, h);
        do_reset();
        // async reset during the second cycle of ld T6
        run_instr(32'h00A20000, 0, 3, 0, 7, h);
        @(negedge clk);
        check("abort_rst", idle(1, 0));
        reset = 1'b0;

        for (int t = 0; t < 200; t++) begin
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 11)];
            d1 = ($urandom_range(0, 11) == 0) ? WL + $urandom_range(0, 1) : $urandom_range(0, 3);
            d2 = ($urandom_range(0, 11) == 0) ? WL + $urandom_range(0, 1) : $urandom_range(0, 3);
            run_instr({op, 27'($urandom)}, d1, d2, ($urandom_range(0, 5) == 0), -1, h);
            if (h) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
